// File: rtl/matrix_calc_dispatcher_pkg.sv
// matrix_calc_dispatcher_pkg: shared calc-type encoding, dispatcher state and status types
package matrix_calc_dispatcher_pkg;
  localparam int NUM_UNITS = 4;
  typedef enum logic [2:0] {TRANSPOSE = 3'd0, ADD = 3'd1, MUL = 3'd2, SCALAR_MUL = 3'd3} calc_type_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} dispatch_state_t;
  typedef enum logic [1:0] {ST_OK, ST_UNIT_ERR, ST_TIMEOUT, ST_BAD_OP} dispatch_status_t;
endpackage

// File: rtl/matrix_dispatch_watchdog.sv
// matrix_dispatch_watchdog: counts enabled cycles; expired flags the TIMEOUT_CYCLES-th enabled cycle
module matrix_dispatch_watchdog #(
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] count;
  assign expired = enable && (count == W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (enable && !expired) count <= count + W'(1);
  end
endmodule

// File: rtl/matrix_calc_dispatcher.sv
// matrix_calc_dispatcher: issues one matrix op to a compute unit and returns its status.
// Define MATRIX_DISPATCH_TIMEOUT_EN to build the watchdog, unit_abort and TIMEOUT status.
module matrix_calc_dispatcher
  import matrix_calc_dispatcher_pkg::*;
#(
  parameter int ID_WIDTH       = 3,
  parameter int SCALAR_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_calc_type,
  input  logic [ID_WIDTH-1:0]     req_id_a,
  input  logic [ID_WIDTH-1:0]     req_id_b,
  input  logic [SCALAR_WIDTH-1:0] req_scalar,
  output logic [NUM_UNITS-1:0]    unit_start,
  output logic [NUM_UNITS-1:0]    unit_abort,
  output logic [ID_WIDTH-1:0]     op_id_a,
  output logic [ID_WIDTH-1:0]     op_id_b,
  output logic [SCALAR_WIDTH-1:0] op_scalar,
  input  logic [NUM_UNITS-1:0]    unit_done,
  input  logic [NUM_UNITS-1:0]    unit_error,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [1:0]              resp_status,
  output logic                    busy
);
  dispatch_state_t state, state_n;
  logic [NUM_UNITS-1:0] sel_q, req_sel;
  logic type_ok, accept, hit_done, hit_err, expired, timeout;
  assign type_ok   = req_calc_type <= 3'(SCALAR_MUL);
  assign req_sel   = type_ok ? NUM_UNITS'(1) << req_calc_type[1:0] : '0;
  assign accept    = state == IDLE && req_valid;
  assign hit_done  = |(unit_done & sel_q);
  assign hit_err   = |(unit_error & sel_q);
  assign timeout   = state == WAIT && expired && !hit_done && !hit_err;
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
`ifdef MATRIX_DISPATCH_TIMEOUT_EN
  // Abort is decided in the same cycle as the timeout so a coinciding done/error can still suppress it
  assign unit_abort = timeout ? sel_q : '0;
  matrix_dispatch_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk(clk), .rst_n(rst_n), .clear(state == ISSUE), .enable(state == WAIT), .expired(expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign unit_abort = '0;
  assign expired    = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req_valid ? (type_ok ? ISSUE : RESPOND) : IDLE;
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = (hit_err || hit_done || timeout) ? RESPOND : WAIT;
      RESPOND: state_n = resp_ready ? IDLE : RESPOND;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel_q       <= '0;
      unit_start  <= '0;
      op_id_a     <= '0;
      op_id_b     <= '0;
      op_scalar   <= '0;
      resp_valid  <= 1'b0;
      resp_status <= ST_OK;
    end else begin
      state      <= state_n;
      unit_start <= (accept && type_ok) ? req_sel : '0;
      resp_valid <= state_n == RESPOND;
      if (accept) begin
        sel_q     <= req_sel;
        op_id_a   <= req_id_a;
        op_id_b   <= req_id_b;
        op_scalar <= req_scalar;
        if (!type_ok) resp_status <= ST_BAD_OP;
      end
      if (state == WAIT && state_n == RESPOND)
        resp_status <= hit_err ? ST_UNIT_ERR : hit_done ? ST_OK : ST_TIMEOUT;
    end
  end
endmodule

// File: tb/tb_matrix_calc_dispatcher.sv
// tb_matrix_calc_dispatcher: scoreboard bench with randomized requests and a status reference model
module tb_matrix_calc_dispatcher;
  localparam int T = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b0, busy;
  logic [2:0] req_calc_type = '0, req_id_a = '0, req_id_b = '0, op_id_a, op_id_b;
  logic [31:0] req_scalar = '0, op_scalar;
  logic [3:0] unit_start, unit_abort, unit_done = '0, unit_error = '0;
  logic [1:0] resp_status;
  int checks = 0, failures = 0;
  logic [1:0] exp_q[$];
  logic held = 1'b0;
  logic [1:0] last_status = '0;

  matrix_calc_dispatcher #(.ID_WIDTH(3), .SCALAR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_calc_type(req_calc_type), .req_id_a(req_id_a), .req_id_b(req_id_b),
    .req_scalar(req_scalar), .unit_start(unit_start), .unit_abort(unit_abort),
    .op_id_a(op_id_a), .op_id_b(op_id_b), .op_scalar(op_scalar),
    .unit_done(unit_done), .unit_error(unit_error), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_status(resp_status), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // mode: 0 done, 1 error, 2 done+error, 3 ignored noise then done, 4 no reply (timeout)
  function automatic logic [1:0] model(int t, int mode);
    if (t > 3) return 2'd3;
    if (mode == 1 || mode == 2) return 2'd1;
    if (mode == 4) return 2'd2;
    return 2'd0;
  endfunction

  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (held) chk("resp_status_stable", int'(resp_status), int'(last_status));
      if (resp_ready) begin
        if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
        else chk("resp_status", int'(resp_status), int'(exp_q.pop_front()));
      end
      held = !resp_ready;
      last_status = resp_status;
    end else held = 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(int t, int ia, int ib, int mode, int d, int k);
    logic [3:0] sel;
    logic [2:0] a, b;
    logic [31:0] s;
    sel = (t < 4) ? 4'(1 << t) : 4'b0;
    a = 3'(ia);
    b = 3'(ib);
    s = $urandom;
    chk("req_ready_idle", int'(req_ready), 1);
    req_valid = 1'b1;
    req_calc_type = 3'(t);
    req_id_a = a;
    req_id_b = b;
    req_scalar = s;
    exp_q.push_back(model(t, mode));
    step();
    req_valid = 1'b0;
    chk("unit_start", int'(unit_start), int'(sel));
    chk("busy", int'(busy), 1);
    if (t > 3) chk("bad_op_resp_valid", int'(resp_valid), 1);
    else begin
      if (mode == 3) begin
        unit_done = sel;
        unit_error = sel;
      end
      step();
      unit_done = '0;
      unit_error = '0;
      chk("start_one_cycle", int'(unit_start), 0);
      if (mode == 4) begin
        for (int w = 0; w < T - 1; w++) begin
          chk("no_early_abort", int'(unit_abort), 0);
          step();
        end
        chk("unit_abort", int'(unit_abort), int'(sel));
        step();
        chk("abort_one_cycle", int'(unit_abort), 0);
      end else begin
        for (int w = 0; w < d; w++) begin
          if (mode == 3) begin
            unit_done = ~sel;
            unit_error = ~sel;
          end
          step();
          unit_done = '0;
          unit_error = '0;
        end
        unit_done = (mode != 1) ? sel : '0;
        unit_error = (mode == 1 || mode == 2) ? sel : '0;
        #1;
        chk("no_abort_on_reply", int'(unit_abort), 0);
        chk("no_early_resp", int'(resp_valid), 0);
        step();
        unit_done = '0;
        unit_error = '0;
      end
      chk("resp_valid", int'(resp_valid), 1);
      chk("op_id_a", int'(op_id_a), int'(a));
      chk("op_id_b", int'(op_id_b), int'(b));
      chk("op_scalar", int'(op_scalar), int'(s));
    end
    for (int i = 0; i < k; i++) begin
      step();
      chk("resp_held", int'(resp_valid), 1);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("resp_released", int'(resp_valid), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_unit_start", int'(unit_start), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_status", int'(resp_status), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_op_id_a", int'(op_id_a), 0);
    rst_n = 1'b1;
    step();
    chk("rst_req_ready", int'(req_ready), 1);
    do_req(1, 1, 2, 0, 4, 0);
    do_req(5, 3, 4, 0, 0, 4);
    do_req(2, 5, 6, 3, 3, 1);
    do_req(2, 7, 0, 2, 2, 0);
`ifdef MATRIX_DISPATCH_TIMEOUT_EN
    do_req(3, 2, 0, 4, 0, 2);
    do_req(0, 4, 1, 0, T - 1, 0);
    do_req(1, 6, 3, 1, T - 1, 1);
`endif
    for (int i = 0; i < 40; i++) begin
`ifdef MATRIX_DISPATCH_TIMEOUT_EN
      do_req($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 3));
`else
      do_req($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3));
`endif
    end
    req_valid = 1'b1;
    req_calc_type = 3'd1;
    req_id_a = 3'd5;
    req_id_b = 3'd6;
    step();
    req_valid = 1'b0;
    step();
    step();
    chk("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_unit_start", int'(unit_start), 0);
    chk("mid_rst_unit_abort", int'(unit_abort), 0);
    chk("mid_rst_resp_valid", int'(resp_valid), 0);
    chk("mid_rst_op_id_a", int'(op_id_a), 0);
    chk("mid_rst_op_id_b", int'(op_id_b), 0);
    step();
    rst_n = 1'b1;
    step();
    do_req(0, 3, 0, 0, 1, 0);
    repeat (2) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end
endmodule
